// File: rtl/mips_lsu_bus.sv
// mips_lsu_bus: Avalon-MM load/store unit for the multicycle MIPS core.
// Runs one byte/half/word access per request: IDLE -> BUS -> RESP -> IDLE.
// All outputs are registered. Build option: define MIPS_LSU_ALIGN_CHECK_EN to
// reject misaligned and reserved-size accesses with resp_err instead of running them.
module mips_lsu_bus #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("mips_lsu_bus: DATA_W must be 32");
  end
  if (ADDR_W < 3) begin : g_bad_addr_w
    $error("mips_lsu_bus: ADDR_W must be >= 3");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_q;
  logic              req_ready_q, resp_valid_q, resp_err_q;
  logic [31:0]       resp_rdata_q, writedata_q;
  logic [ADDR_W-1:0] address_q;
  logic              read_q, write_q;
  logic [3:0]        byteenable_q;
  logic [1:0]        size_q, off_q;
  logic              signed_q;

  logic [3:0]        be_new;
  logic [31:0]       wd_new;
  logic [1:0]        off_new;
  logic              reject;
  logic [31:0]       shifted;
  logic [31:0]       load_data;

  // Lane, data replication and lane offset for the incoming request.
  always_comb begin
    be_new  = 4'b1111;
    wd_new  = req_wdata;
    off_new = 2'b00;
    unique case (req_size)
      2'b00: begin
        be_new  = 4'b0001 << req_addr[1:0];
        wd_new  = {4{req_wdata[7:0]}};
        off_new = req_addr[1:0];
      end
      2'b01: begin
        be_new  = 4'b0011 << {req_addr[1], 1'b0};
        wd_new  = {2{req_wdata[15:0]}};
        off_new = {req_addr[1], 1'b0};
      end
      default: ; // word and reserved size both behave as word
    endcase
  end

  // Alignment rejection (only with the check built in).
  always_comb begin
`ifdef MIPS_LSU_ALIGN_CHECK_EN
    reject = (req_size == 2'b11) ||
             (req_size == 2'b01 && req_addr[0]) ||
             (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
    reject = 1'b0;
`endif
  end

  // Pull the addressed lane(s) down to bit 0 and extend.
  always_comb begin
    shifted = readdata >> {off_q, 3'b000};
    unique case (size_q)
      2'b00:   load_data = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted; // off_q is 0 for words
    endcase
  end

  // Control FSM and registered bus/response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      signed_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q  <= 1'b0;
            size_q       <= req_size;
            off_q        <= off_new;
            signed_q     <= req_signed;
            resp_rdata_q <= '0;
            if (reject) begin
              // Skip the bus entirely; respond next cycle with an error.
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q      <= BUS;
              address_q    <= {req_addr[ADDR_W-1:2], 2'b00};
              read_q       <= ~req_write;
              write_q      <= req_write;
              byteenable_q <= be_new;
              writedata_q  <= wd_new;
            end
          end
        end
        BUS: begin
          if (!waitrequest) begin
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            byteenable_q <= '0;
            writedata_q  <= '0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= read_q ? load_data : 32'h0;
            state_q      <= RESP;
          end
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;

endmodule

// File: tb/tb_mips_lsu_bus.sv
// tb_mips_lsu_bus: directed + randomized bench for mips_lsu_bus with a
// byte-level reference model of lanes, replication and load extension.
module tb_mips_lsu_bus;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_signed = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic          waitrequest = 1'b0;
  logic [31:0]   writedata;
  logic [3:0]    byteenable;
  logic [31:0]   readdata = '0;

  int checks = 0;
  int failures = 0;

  mips_lsu_bus #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .address    (address),
    .read       (read),
    .write      (write),
    .waitrequest(waitrequest),
    .writedata  (writedata),
    .byteenable (byteenable),
    .readdata   (readdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---- reference model: accesses as a run of bytes within the 32-bit word ----
  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic int lane_off(input logic [1:0] s, input logic [31:0] a);
    if (s == 2'b00) return int'(a[1:0]);
    if (s == 2'b01) return a[1] ? 2 : 0;
    return 0;
  endfunction

  function automatic bit model_err(input logic [1:0] s, input logic [31:0] a);
`ifdef MIPS_LSU_ALIGN_CHECK_EN
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] s, input logic [31:0] a);
    logic [3:0] be = '0;
    for (int k = 0; k < nbytes(s); k++) be[lane_off(s, a) + k] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] s, input logic [31:0] wd);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % nbytes(s)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] s, input bit sg,
                                             input logic [31:0] a, input logic [31:0] rd);
    longint v = 0;
    int n = nbytes(s);
    int o = lane_off(s, a);
    for (int k = n - 1; k >= 0; k--) v = v * 256 + longint'(rd[8*(o+k) +: 8]);
    if (sg && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  // One complete access, called at a negedge with the DUT idle.
  task automatic access(input string tag, input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int nwait, output logic [31:0] got);
    bit err = model_err(sz, a);
    got = 'x;
    chk({tag, ":ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; waitrequest = 1'b0; readdata = $urandom;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    if (err) begin
      chk({tag, ":err_read"}, {31'b0, read}, 32'd0);
      chk({tag, ":err_write"}, {31'b0, write}, 32'd0);
      chk({tag, ":err_valid"}, {31'b0, resp_valid}, 32'd1);
      chk({tag, ":err_flag"}, {31'b0, resp_err}, 32'd1);
      chk({tag, ":err_rdata"}, resp_rdata, 32'd0);
      got = resp_rdata;
    end else begin
      for (int i = 0; i <= nwait; i++) begin
        waitrequest = (i < nwait);
        readdata = (i < nwait) ? $urandom : rd;
        chk({tag, ":read"}, {31'b0, read}, {31'b0, ~wr});
        chk({tag, ":write"}, {31'b0, write}, {31'b0, wr});
        chk({tag, ":addr"}, address, a & 32'hFFFF_FFFC);
        chk({tag, ":be"}, {28'b0, byteenable}, {28'b0, model_be(sz, a)});
        chk({tag, ":wd"}, writedata, wr ? model_wd(sz, wd) : writedata);
        chk({tag, ":busy_valid"}, {31'b0, resp_valid}, 32'd0);
        chk({tag, ":busy_ready"}, {31'b0, req_ready}, 32'd0);
        @(negedge clk);
      end
      waitrequest = 1'b0;
      chk({tag, ":valid"}, {31'b0, resp_valid}, 32'd1);
      chk({tag, ":errflag"}, {31'b0, resp_err}, 32'd0);
      chk({tag, ":rdata"}, resp_rdata, wr ? 32'd0 : model_load(sz, sg, a, rd));
      chk({tag, ":idle_bus"}, {26'b0, read, write, byteenable}, 32'd0);
      chk({tag, ":idle_wd"}, writedata, 32'd0);
      got = resp_rdata;
    end
    @(negedge clk);
    chk({tag, ":pulse_end"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, ":ready_again"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] got;

    // Asynchronous reset mid-cycle: outputs take reset values immediately.
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_rw", {30'b0, read, write}, 32'd0);
    chk("rst_addr", address, 32'd0);
    chk("rst_wd", writedata, 32'd0);
    chk("rst_be", {28'b0, byteenable}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // sb 0x1001 <- 0xAB
    access("sb", 1'b1, 2'b00, 1'b0, 32'h1001, 32'h0000_00AB, 32'h0, 0, got);
    // lb / lbu 0x1003 with readdata 0x80123456
    access("lb", 1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 32'h8012_3456, 0, got);
    chk("lb_const", got, 32'hFFFF_FF80);
    access("lbu", 1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 32'h8012_3456, 0, got);
    chk("lbu_const", got, 32'h0000_0080);
    // lhu 0x2002 with three stall cycles
    access("lhu", 1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, 32'hBEEF_1234, 3, got);
    chk("lhu_const", got, 32'h0000_BEEF);
    // sh / sw replication and a signed half load
    access("sh", 1'b1, 2'b01, 1'b0, 32'h4002, 32'hDEAD_C0DE, 32'h0, 1, got);
    access("sw", 1'b1, 2'b10, 1'b0, 32'h4004, 32'h1234_5678, 32'h0, 0, got);
    access("lh", 1'b0, 2'b01, 1'b1, 32'h4000, 32'h0, 32'h0000_9ABC, 0, got);
    chk("lh_const", got, 32'hFFFF_9ABC);
    // Misaligned word load and reserved size
    access("lw_mis", 1'b0, 2'b10, 1'b1, 32'h1002, 32'h0, 32'hCAFE_F00D, 0, got);
`ifdef MIPS_LSU_ALIGN_CHECK_EN
    chk("lw_mis_const", got, 32'h0);
`else
    chk("lw_mis_const", got, 32'hCAFE_F00D);
`endif
    access("sz11", 1'b0, 2'b11, 1'b0, 32'h1000, 32'h0, 32'h8765_4321, 0, got);

    // Abort: reset while stalled in BUS.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 32'h3000; waitrequest = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_read_on", {31'b0, read}, 32'd1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_read_off", {31'b0, read}, 32'd0);
    chk("abort_be", {28'b0, byteenable}, 32'd0);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_resp", {31'b0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    access("after_abort", 1'b0, 2'b10, 1'b0, 32'h3004, 32'h0, 32'h0BAD_BEEF, 0, got);

    // Randomized accesses against the model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] s = 2'($urandom_range(0, 3));
      access($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom, int'($urandom_range(0, 3)), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
